// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, captures memory bytes into IF/ID, resolves
// short unconditional jumps early and stops when the PC leaves populated memory.
module instruction_fetch_unit #(
  parameter int MEM_DEPTH      = 36,
  parameter bit JUMP_PREDECODE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] pc_out,
  input  logic [7:0] instr_in,
  input  logic       stall,
  input  logic       redirect,
  input  logic [7:0] redirect_target,
  output logic [7:0] if_id_instr,
  output logic [7:0] if_id_pc,
  output logic       if_id_valid,
  output logic       halted,
  output logic [7:0] fetch_count
);

  typedef enum logic [1:0] {INIT, FETCH, HALT} state_t;

  localparam logic [8:0] DEPTH = 9'(MEM_DEPTH);

  state_t     state, state_n;
  logic [7:0] pc, pc_n, instr_n, ipc_n, cnt_n;
  logic       valid_n, halted_n;
  logic [7:0] jump_off, seq_pc;
  logic       tgt_ok, seq_ok;

  // Opcode 2'b11 carries a signed 6-bit displacement relative to pc+1.
  always_comb begin
    jump_off = 8'h00;
    if (JUMP_PREDECODE && instr_in[7:6] == 2'b11)
      jump_off = {{2{instr_in[5]}}, instr_in[5:0]};
    seq_pc = pc + 8'd1 + jump_off;
    seq_ok = {1'b0, seq_pc} < DEPTH;
    tgt_ok = {1'b0, redirect_target} < DEPTH;
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    instr_n  = if_id_instr;
    ipc_n    = if_id_pc;
    valid_n  = if_id_valid;
    halted_n = halted;
    cnt_n    = fetch_count;
    case (state)
      INIT: state_n = FETCH;
      FETCH: begin
        if (redirect) begin
          pc_n    = redirect_target;
          valid_n = 1'b0;
          instr_n = 8'h00;
          if (!tgt_ok) begin
            state_n  = HALT;
            halted_n = 1'b1;
          end
        end else if (!stall) begin
          instr_n = instr_in;
          ipc_n   = pc;
          valid_n = 1'b1;
          cnt_n   = (fetch_count == 8'hFF) ? 8'hFF : fetch_count + 8'd1;
          pc_n    = seq_pc;
          // The capture on this edge is kept even though the PC runs off the end.
          if (!seq_ok) begin
            state_n  = HALT;
            halted_n = 1'b1;
          end
        end
      end
      HALT: begin
        valid_n = 1'b0;
        if (redirect) begin
          pc_n = redirect_target;
          if (tgt_ok) begin
            state_n  = FETCH;
            halted_n = 1'b0;
          end
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= INIT;
      pc          <= 8'h00;
      if_id_instr <= 8'h00;
      if_id_pc    <= 8'h00;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= 8'h00;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_id_instr <= instr_n;
      if_id_pc    <= ipc_n;
      if_id_valid <= valid_n;
      halted      <= halted_n;
      fetch_count <= cnt_n;
    end
  end

  assign pc_out = pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: two fetch units (jump predecode on/off) share one stimulus
// stream; an integer-level model predicts each edge, a monitor compares.
module tb_instruction_fetch_unit;

  localparam int DEPTH = 36;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stall = 1'b0, redirect = 1'b0;
  logic [7:0] redirect_target = 8'h00;
  logic [7:0] mem [256];

  logic [7:0] pc_a, instr_a, iid_a, ipc_a, cnt_a;
  logic       val_a, hlt_a;
  logic [7:0] pc_b, instr_b, iid_b, ipc_b, cnt_b;
  logic       val_b, hlt_b;

  assign instr_a = mem[pc_a];
  assign instr_b = mem[pc_b];

  instruction_fetch_unit #(.MEM_DEPTH(DEPTH), .JUMP_PREDECODE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .pc_out(pc_a), .instr_in(instr_a),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .if_id_instr(iid_a), .if_id_pc(ipc_a), .if_id_valid(val_a),
    .halted(hlt_a), .fetch_count(cnt_a));

  instruction_fetch_unit #(.MEM_DEPTH(DEPTH), .JUMP_PREDECODE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .pc_out(pc_b), .instr_in(instr_b),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .if_id_instr(iid_b), .if_id_pc(ipc_b), .if_id_valid(val_b),
    .halted(hlt_b), .fetch_count(cnt_b));

  always #5 clk = ~clk;

  // phase: 0 = waiting for the settle edge, 1 = running, 2 = stopped
  typedef struct {
    int pc; int instr; int ipc; bit valid; bit halted; int cnt; int phase;
  } mst_t;
  typedef struct { mst_t a; mst_t b; } exp_t;

  mst_t ma, mb, rst_m;
  exp_t q[$];
  int   n_chk = 0, n_pass = 0;
  event mon_ev;

  function automatic mst_t mstep(mst_t s, bit jp, bit st, bit rd, int tgt, int ins);
    mst_t n = s;
    int off;
    if (s.phase == 0) begin
      n.phase = 1;
    end else if (s.phase == 1) begin
      if (rd) begin
        n.pc = tgt; n.valid = 0; n.instr = 0;
        if (tgt >= DEPTH) begin n.phase = 2; n.halted = 1; end
      end else if (!st) begin
        n.instr = ins; n.ipc = s.pc; n.valid = 1;
        n.cnt = (s.cnt + 1 > 255) ? 255 : s.cnt + 1;
        off = 0;
        if (jp && ins >= 192) begin
          off = ins % 64;
          if (off >= 32) off = off - 64;
        end
        n.pc = (s.pc + 1 + off + 256) % 256;
        if (n.pc >= DEPTH) begin n.phase = 2; n.halted = 1; end
      end
    end else begin
      n.valid = 0;
      if (rd) begin
        n.pc = tgt;
        if (tgt < DEPTH) begin n.phase = 1; n.halted = 0; end
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares whenever the DUT outputs have settled after an edge
  // (or right after an asynchronous reset, before the next edge).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or mon_ev);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("a.pc_out",      pc_a,  e.a.pc);
        chk("a.if_id_instr", iid_a, e.a.instr);
        chk("a.if_id_pc",    ipc_a, e.a.ipc);
        chk("a.if_id_valid", val_a, e.a.valid);
        chk("a.halted",      hlt_a, e.a.halted);
        chk("a.fetch_count", cnt_a, e.a.cnt);
        chk("b.pc_out",      pc_b,  e.b.pc);
        chk("b.if_id_instr", iid_b, e.b.instr);
        chk("b.if_id_pc",    ipc_b, e.b.ipc);
        chk("b.if_id_valid", val_b, e.b.valid);
        chk("b.halted",      hlt_b, e.b.halted);
        chk("b.fetch_count", cnt_b, e.b.cnt);
      end
    end
  end

  task automatic hold_reset(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      reset = 1'b0; stall = 1'b0; redirect = 1'b0;
      ma = rst_m; mb = rst_m;
      q.push_back('{a: ma, b: mb});
    end
  endtask

  task automatic cyc(input bit st, input bit rd, input int tgt);
    @(negedge clk); #1;
    reset = 1'b1; stall = st; redirect = rd; redirect_target = 8'(tgt);
    ma = mstep(ma, 1'b1, st, rd, tgt, int'(mem[ma.pc]));
    mb = mstep(mb, 1'b0, st, rd, tgt, int'(mem[mb.pc]));
    q.push_back('{a: ma, b: mb});
  endtask

  // Pull reset low between edges and check before the next rising edge.
  task automatic async_reset();
    @(negedge clk); #1;
    reset = 1'b0; stall = 1'b0; redirect = 1'b0;
    ma = rst_m; mb = rst_m;
    q.push_back('{a: ma, b: mb});
    #1 -> mon_ev;
  endtask

  task automatic load_prog();
    logic [7:0] p [7];
    p = '{8'h1B, 8'h59, 8'h1B, 8'hC5, 8'h5B, 8'h3B, 8'h00};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 7; i++) mem[i] = p[i];
    mem[35] = 8'hA7;
  endtask

  task automatic load_random();
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(4) == 0) ? (8'hC0 | 8'($urandom_range(63)))
                                        : 8'($urandom_range(191));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_m = '{pc: 0, instr: 0, ipc: 0, valid: 0, halted: 0, cnt: 0, phase: 0};
    ma = rst_m; mb = rst_m;
    load_prog();
    hold_reset(3);

    // straight-line fetch, jump C5 at pc 3 (a: to 9, b: to 4)
    repeat (7) cyc(0, 0, 0);
    hold_reset(2);
    // stall for two cycles with pc_out = 2
    repeat (3) cyc(0, 0, 0);
    repeat (2) cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    hold_reset(2);
    // redirect and stall together at pc_out = 1
    repeat (2) cyc(0, 0, 0);
    cyc(1, 1, 4);
    repeat (2) cyc(0, 0, 0);
    // run off the end at 35, stall in HALT, bad redirect, then recover
    cyc(0, 1, 35);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 200);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (2) cyc(0, 0, 0);
    // asynchronous reset mid-fetch at pc = 5, then restart
    hold_reset(2);
    repeat (2) cyc(0, 0, 0);
    cyc(0, 1, 4);
    cyc(0, 0, 0);
    async_reset();
    hold_reset(1);
    repeat (6) cyc(0, 0, 0);

    // randomized program and control, long enough to saturate fetch_count
    hold_reset(1);
    load_random();
    hold_reset(2);
    repeat (2500) begin
      bit rd, st;
      int tgt;
      rd  = ($urandom_range(7) == 0);
      st  = ($urandom_range(3) == 0);
      tgt = ($urandom_range(9) == 0) ? int'($urandom_range(255)) : int'($urandom_range(DEPTH + 4));
      cyc(st, rd, tgt);
    end

    @(negedge clk); #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
